// File: rtl/mmcm_reset_seq.sv
// Initiator side of the MMCM reset/lock handshake: pulses MMCM RESET, qualifies LOCKED
// over a stability window, releases a downstream reset, and retries or fails on timeout.
module mmcm_reset_seq #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 65535,
    parameter int STABLE_CYCLES    = 256,
    parameter int MAX_RETRIES      = 3,
    parameter int CNT_W            = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
    input  logic       restart,
    output logic       mmcm_reset,
    output logic       rst_out,
    output logic       lock_lost,
    output logic       fail,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        ST_RST_ASSERT,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         retry_count_q, retry_count_d;
    logic               sync1_q, sync1_d;
    logic               locked_s_q, locked_s_d;
    logic               mmcm_reset_q, mmcm_reset_d;
    logic               rst_out_q, rst_out_d;
    logic               lock_lost_q, lock_lost_d;
    logic               fail_q, fail_d;
    logic               retry_ok;

    assign retry_ok = (retry_count_q < 4'(MAX_RETRIES));

    // locked is asynchronous to clk; only locked_s is used by the FSM
    always_comb begin
        sync1_d    = locked;
        locked_s_d = sync1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RST_ASSERT;
            cnt_q         <= '0;
            retry_count_q <= '0;
            sync1_q       <= 1'b0;
            locked_s_q    <= 1'b0;
            mmcm_reset_q  <= 1'b1;
            rst_out_q     <= 1'b1;
            lock_lost_q   <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_count_q <= retry_count_d;
            sync1_q       <= sync1_d;
            locked_s_q    <= locked_s_d;
            mmcm_reset_q  <= mmcm_reset_d;
            rst_out_q     <= rst_out_d;
            lock_lost_q   <= lock_lost_d;
            fail_q        <= fail_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        retry_count_d = retry_count_q;
        case (state_q)
            ST_RST_ASSERT: begin
                if (cnt_q == CNT_W'(RST_PULSE_CYCLES - 1)) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_d = '0;
                    if (retry_ok) begin
                        retry_count_d = retry_count_q + 4'd1;
                        state_d       = ST_RST_ASSERT;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                // A lock drop during qualification counts as a failed attempt
                if (!locked_s_q) begin
                    cnt_d = '0;
                    if (retry_ok) begin
                        retry_count_d = retry_count_q + 4'd1;
                        state_d       = ST_RST_ASSERT;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked_s_q) begin
                    state_d       = ST_RST_ASSERT;
                    cnt_d         = '0;
                    retry_count_d = '0;
                end
            end
            ST_FAIL: begin
                if (restart) begin
                    state_d       = ST_RST_ASSERT;
                    cnt_d         = '0;
                    retry_count_d = '0;
                end
            end
            default: begin
                state_d       = ST_RST_ASSERT;
                cnt_d         = '0;
                retry_count_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the transition edge
    always_comb begin
        mmcm_reset_d = (state_d == ST_RST_ASSERT) || (state_d == ST_FAIL);
        rst_out_d    = (state_d != ST_RUN);
        fail_d       = (state_d == ST_FAIL);
        lock_lost_d  = (state_q == ST_RUN) && !locked_s_q;
    end

    assign mmcm_reset  = mmcm_reset_q;
    assign rst_out     = rst_out_q;
    assign lock_lost   = lock_lost_q;
    assign fail        = fail_q;
    assign retry_count = retry_count_q;

endmodule

// File: tb/tb_mmcm_reset_seq.sv
// Directed bench for mmcm_reset_seq with short timing parameters; edges counted by hand.
module tb_mmcm_reset_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       locked;
    logic       restart;
    logic       mmcm_reset;
    logic       rst_out;
    logic       lock_lost;
    logic       fail;
    logic [3:0] retry_count;

    int total = 0;
    int bad   = 0;

    mmcm_reset_seq #(
        .RST_PULSE_CYCLES(4),
        .LOCK_TIMEOUT    (20),
        .STABLE_CYCLES   (8),
        .MAX_RETRIES     (2),
        .CNT_W           (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .locked     (locked),
        .restart    (restart),
        .mmcm_reset (mmcm_reset),
        .rst_out    (rst_out),
        .lock_lost  (lock_lost),
        .fail       (fail),
        .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        locked  = 1'b0;
        restart = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mmcm_reset", mmcm_reset, 1);
        chk("rst_rst_out", rst_out, 1);
        chk("rst_lock_lost", lock_lost, 0);
        chk("rst_fail", fail, 0);
        chk("rst_retry", retry_count, 0);

        // Normal bring-up: 4-cycle pulse, lock 10 cycles later, release on 11th edge
        reset = 1'b0;
        tick(3);
        chk("s1_pulse_hi", mmcm_reset, 1);
        tick(1);
        chk("s1_pulse_lo", mmcm_reset, 0);
        tick(10);
        locked = 1'b1;
        tick(10);
        chk("s1_rst_out_e10", rst_out, 1);
        tick(1);
        chk("s1_rst_out_e11", rst_out, 0);
        chk("s1_retry", retry_count, 0);
        chk("s1_fail", fail, 0);
        chk("s1_mmcm_lo", mmcm_reset, 0);

        // Lock never arrives: three attempts then FAIL
        reset  = 1'b1;
        locked = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(3);
        chk("s2_p1_hi", mmcm_reset, 1);
        tick(1);
        chk("s2_p1_lo", mmcm_reset, 0);
        tick(19);
        chk("s2_w1_end_mmcm", mmcm_reset, 0);
        chk("s2_w1_end_retry", retry_count, 0);
        tick(1);
        chk("s2_p2_start", mmcm_reset, 1);
        chk("s2_retry1", retry_count, 1);
        tick(3);
        chk("s2_p2_hi", mmcm_reset, 1);
        tick(1);
        chk("s2_p2_lo", mmcm_reset, 0);
        tick(19);
        chk("s2_w2_end_mmcm", mmcm_reset, 0);
        tick(1);
        chk("s2_p3_start", mmcm_reset, 1);
        chk("s2_retry2", retry_count, 2);
        tick(3);
        chk("s2_p3_hi", mmcm_reset, 1);
        tick(1);
        chk("s2_p3_lo", mmcm_reset, 0);
        tick(19);
        chk("s2_w3_end_fail", fail, 0);
        tick(1);
        chk("s2_fail", fail, 1);
        chk("s2_fail_mmcm", mmcm_reset, 1);
        chk("s2_fail_rst_out", rst_out, 1);
        chk("s2_fail_retry", retry_count, 2);
        tick(5);
        chk("s2_fail_hold", fail, 1);
        chk("s2_fail_hold_mmcm", mmcm_reset, 1);

        // Restart from FAIL with lock present
        locked  = 1'b1;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("s3_fail_clr", fail, 0);
        chk("s3_retry_clr", retry_count, 0);
        tick(3);
        chk("s3_pulse_hi", mmcm_reset, 1);
        tick(1);
        chk("s3_pulse_lo", mmcm_reset, 0);
        tick(8);
        chk("s3_rst_out_hi", rst_out, 1);
        tick(1);
        chk("s3_rst_out_lo", rst_out, 0);

        // Lock loss in RUN for 5 cycles
        locked = 1'b0;
        tick(2);
        chk("s4_no_pulse_yet", lock_lost, 0);
        chk("s4_still_run", rst_out, 0);
        tick(1);
        chk("s4_lock_lost", lock_lost, 1);
        chk("s4_rst_out", rst_out, 1);
        chk("s4_mmcm", mmcm_reset, 1);
        chk("s4_retry", retry_count, 0);
        tick(1);
        chk("s4_lost_one_cycle", lock_lost, 0);
        tick(1);
        locked = 1'b1;
        tick(1);
        chk("s4_pulse_hi", mmcm_reset, 1);
        tick(1);
        chk("s4_pulse_lo", mmcm_reset, 0);
        tick(8);
        chk("s4_relock_hi", rst_out, 1);
        tick(1);
        chk("s4_relock_lo", rst_out, 0);

        // Lock drop while in STABLE at count 4 -> retry
        locked = 1'b0;
        tick(3);
        chk("s5_lock_lost", lock_lost, 1);
        locked = 1'b1;
        tick(4);
        chk("s5_pulse_lo", mmcm_reset, 0);
        tick(5);
        locked = 1'b0;
        tick(2);
        chk("s5_pre_retry", retry_count, 0);
        chk("s5_pre_mmcm", mmcm_reset, 0);
        chk("s5_pre_rst_out", rst_out, 1);
        tick(1);
        chk("s5_retry", retry_count, 1);
        chk("s5_mmcm", mmcm_reset, 1);
        chk("s5_rst_out", rst_out, 1);
        tick(4);
        chk("s5_wait_mmcm", mmcm_reset, 0);
        chk("s5_wait_retry", retry_count, 1);
        chk("s5_wait_rst_out", rst_out, 1);

        // Async reset mid-WAIT_LOCK, restart held alongside reset
        tick(5);
        #2;
        reset   = 1'b1;
        restart = 1'b1;
        #1;
        chk("s6_mmcm", mmcm_reset, 1);
        chk("s6_rst_out", rst_out, 1);
        chk("s6_retry", retry_count, 0);
        chk("s6_fail", fail, 0);
        chk("s6_lock_lost", lock_lost, 0);
        tick(3);
        chk("s6_hold_mmcm", mmcm_reset, 1);
        chk("s6_hold_retry", retry_count, 0);
        restart = 1'b0;
        reset   = 1'b0;
        tick(3);
        chk("s6_restart_hi", mmcm_reset, 1);
        tick(1);
        chk("s6_restart_lo", mmcm_reset, 0);
        chk("s6_restart_fail", fail, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
